alu_op_issue: RTL and testbench
===============================

ALU_OP_ISSUE -- requirements
Module: alu_op_issue

Interface
REQ-001 SHALL have parameter OPCODE_LENGTH, default 4, width of the ALU Operation code.
REQ-002 SHALL have parameter CNT_WIDTH, default 8, width of the illegal-op counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port reset_n, input, 1, reset; asynchronous assert, active-low.
REQ-005 SHALL have port in_valid, input, 1, decode stage presents an instruction.
REQ-006 SHALL have port ALUOp, input, 2, class: 00 mem/addr, 01 branch, 10 R/I arithmetic, 11 reserved.
REQ-007 SHALL have port Funct3, input, 3, instruction funct3.
REQ-008 SHALL have port Funct7, input, 7, instruction funct7; only bit 5 is used.
REQ-009 SHALL have port is_rtype, input, 1, high for R-type; low for I-type.
REQ-010 SHALL have ports stall, input, 1, hold the register; and flush, input, 1, insert a bubble.
REQ-011 SHALL have port Operation, output, OPCODE_LENGTH, registered ALU operation to EX.
REQ-012 SHALL have ports out_valid, output, 1; is_branch, output, 1; illegal, output, 1, registered, per issued op.
REQ-013 SHALL have ports illegal_sticky, output, 1; illegal_cnt, output, CNT_WIDTH (macro only, REQ-027).

Function
REQ-014 SHALL decode ALUOp=00 to ADD 0010.
REQ-015 SHALL decode ALUOp=01 by Funct3: 000/001 -> BEQ 1000; 100 -> BLT 1001; 101 -> BGE 1010; other -> ADD with illegal=1; is_branch=1 for all.
REQ-016 SHALL decode ALUOp=10 by Funct3: 000 -> SUB 0110 if is_rtype&Funct7[5] else ADD; 001 SLL 0100; 010 SLT 1100; 100 XOR 0011; 101 -> SRA 0111 if Funct7[5] else SRL 0101; 110 OR 0001; 111 AND 0000; 011 -> ADD with illegal=1.
REQ-017 SHALL decode ALUOp=11 to ADD with illegal=1.
REQ-018 SHALL register decoded fields one cycle after capture (latency 1); no combinational path inputs -> outputs.
REQ-019 SHALL, per edge, with priority flush > stall > load: flush -> bubble; stall -> hold all outputs; else load decode with out_valid=in_valid.
REQ-020 SHALL define a bubble as Operation=0000, out_valid=0, is_branch=0, illegal=0.
REQ-021 SHALL, when in_valid=0 and loading, load a bubble (decoded fields not captured).
REQ-022 SHALL set illegal_sticky on any load with in_valid=1 and illegal decode; cleared only by reset.
REQ-023 SHALL not count or flag an instruction that is flushed or arrives during stall.

Reset
REQ-024 SHALL, on reset_n low, immediately drive Operation=0000, out_valid=0, is_branch=0, illegal=0, illegal_sticky=0, illegal_cnt=0.
REQ-025 SHALL discard any instruction in flight on reset mid-operation; first load is on the first edge after reset_n rises.

Configuration
REQ-026 SHALL use macro ALU_OP_ISSUE_ILLEGAL_CNT_EN.
REQ-027 SHALL, with the macro, provide illegal_cnt incrementing on each counted illegal load, saturating at all-ones; without it, port illegal_cnt and its counter are absent; all else identical.

Structure
REQ-028 SHALL take Operation encodings (AND..SLT) and ALUOp class constants from shared package alu_pkg, also used by the ALU.
REQ-029 SHALL place the pure decode in sub-module alu_op_decode (combinational); alu_op_issue holds the registers, priority logic and counter.

Verification
REQ-030 ALUOp=10, Funct3=000, Funct7=0100000, is_rtype=1, in_valid=1 -> next cycle Operation=0110, out_valid=1; same with is_rtype=0 -> 0010.
REQ-031 ALUOp=01, Funct3=101 -> Operation=1010, is_branch=1; Funct3=010 -> 0010, illegal=1, illegal_sticky=1.
REQ-032 Load XOR (Funct3=100), then stall=1 for 3 cycles with inputs changed to AND -> Operation stays 0011 for 3 cycles, then 0000 after release.
REQ-033 stall=1 and flush=1 together with valid SRL input -> bubble next cycle (out_valid=0, Operation=0000).
REQ-034 With macro: 300 consecutive ALUOp=11 loads -> illegal_cnt saturates at 255; flushed illegal op -> no increment.
REQ-035 Assert reset_n low between edges after loading SLL -> outputs all zero before next clk edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU operation encodings and ALUOp instruction classes.
// Used by the issue-stage decoder and by the ALU itself.
package alu_pkg;

  localparam int OP_W = 4;

  typedef logic [OP_W-1:0] alu_op_t;
  typedef logic [1:0]      aluop_t;

  localparam alu_op_t OP_AND = 4'b0000;
  localparam alu_op_t OP_OR  = 4'b0001;
  localparam alu_op_t OP_ADD = 4'b0010;
  localparam alu_op_t OP_XOR = 4'b0011;
  localparam alu_op_t OP_SLL = 4'b0100;
  localparam alu_op_t OP_SRL = 4'b0101;
  localparam alu_op_t OP_SUB = 4'b0110;
  localparam alu_op_t OP_SRA = 4'b0111;
  localparam alu_op_t OP_BEQ = 4'b1000;
  localparam alu_op_t OP_BLT = 4'b1001;
  localparam alu_op_t OP_BGE = 4'b1010;
  localparam alu_op_t OP_SLT = 4'b1100;

  localparam aluop_t ALUOP_MEM   = 2'b00;
  localparam aluop_t ALUOP_BR    = 2'b01;
  localparam aluop_t ALUOP_ARITH = 2'b10;
  localparam aluop_t ALUOP_RSVD  = 2'b11;

  typedef struct packed {
    alu_op_t op;
    logic    is_branch;
    logic    illegal;
  } dec_t;

  function automatic dec_t dec_default();
    dec_t d;
    d.op        = OP_ADD;
    d.is_branch = 1'b0;
    d.illegal   = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Pure combinational ALUOp/funct decode into an ALU operation.
// Illegal encodings fall back to ADD with the illegal flag raised.
module alu_op_decode
  import alu_pkg::*;
(
  input  aluop_t      aluop_i,
  input  logic [2:0]  funct3_i,
  input  logic        funct7b5_i,
  input  logic        is_rtype_i,
  output dec_t        dec_o
);

  always_comb begin
    dec_o = dec_default();
    unique case (1'b1)
      (aluop_i == ALUOP_MEM): begin
        dec_o.op = OP_ADD;
      end
      (aluop_i == ALUOP_BR): begin
        dec_o.is_branch = 1'b1;
        case (funct3_i)
          3'b000,
          3'b001:  dec_o.op = OP_BEQ;
          3'b100:  dec_o.op = OP_BLT;
          3'b101:  dec_o.op = OP_BGE;
          default: dec_o.illegal = 1'b1;
        endcase
      end
      (aluop_i == ALUOP_ARITH): begin
        case (funct3_i)
          3'b000:
            dec_o.op = (is_rtype_i && funct7b5_i)
                     ? OP_SUB : OP_ADD;
          3'b001:  dec_o.op = OP_SLL;
          3'b010:  dec_o.op = OP_SLT;
          3'b100:  dec_o.op = OP_XOR;
          3'b101:
            dec_o.op = funct7b5_i ? OP_SRA : OP_SRL;
          3'b110:  dec_o.op = OP_OR;
          3'b111:  dec_o.op = OP_AND;
          default: dec_o.illegal = 1'b1;
        endcase
      end
      default: begin
        dec_o.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_op_issue.sv
// Registered ALU-op issue stage: decode, flush/stall priority, illegal tracking.
// Optional saturating illegal counter: define ALU_OP_ISSUE_ILLEGAL_CNT_EN.
module alu_op_issue
  import alu_pkg::*;
#(
  parameter int OPCODE_LENGTH = 4,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic [1:0]               ALUOp,
  input  logic [2:0]               Funct3,
  input  logic [6:0]               Funct7,
  input  logic                     is_rtype,
  input  logic                     stall,
  input  logic                     flush,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     out_valid,
  output logic                     is_branch,
  output logic                     illegal,
`ifdef ALU_OP_ISSUE_ILLEGAL_CNT_EN
  output logic                     illegal_sticky,
  output logic [CNT_WIDTH-1:0]     illegal_cnt
`else
  output logic                     illegal_sticky
`endif
);

  dec_t dec;

  alu_op_decode u_dec (
    .aluop_i    (ALUOp),
    .funct3_i   (Funct3),
    .funct7b5_i (Funct7[5]),
    .is_rtype_i (is_rtype),
    .dec_o      (dec)
  );

  logic unused_funct7;
  assign unused_funct7 = ^{Funct7[6], Funct7[4:0]};

  logic [OPCODE_LENGTH-1:0] op_q, op_d;
  logic valid_q, valid_d;
  logic br_q, br_d;
  logic ill_q, ill_d;
  logic sticky_q, sticky_d;
  logic take_ill;

  // Only an accepted, valid load may flag or count an illegal op.
  assign take_ill = !flush && !stall
                 && in_valid && dec.illegal;

  always_comb begin
    op_d    = op_q;
    valid_d = valid_q;
    br_d    = br_q;
    ill_d   = ill_q;
    if (flush) begin
      op_d    = '0;
      valid_d = 1'b0;
      br_d    = 1'b0;
      ill_d   = 1'b0;
    end else if (!stall) begin
      op_d    = in_valid
              ? OPCODE_LENGTH'(dec.op) : '0;
      valid_d = in_valid;
      br_d    = in_valid && dec.is_branch;
      ill_d   = in_valid && dec.illegal;
    end
    sticky_d = sticky_q || take_ill;
  end

`ifdef ALU_OP_ISSUE_ILLEGAL_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (take_ill && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign illegal_cnt = cnt_q;
`else
  localparam int unused_cnt_w = CNT_WIDTH;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= '0;
      valid_q  <= 1'b0;
      br_q     <= 1'b0;
      ill_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      op_q     <= op_d;
      valid_q  <= valid_d;
      br_q     <= br_d;
      ill_q    <= ill_d;
      sticky_q <= sticky_d;
    end
  end

  assign Operation      = op_q;
  assign out_valid      = valid_q;
  assign is_branch      = br_q;
  assign illegal        = ill_q;
  assign illegal_sticky = sticky_q;

endmodule

// File: tb/tb_alu_op_issue.sv
// Scoreboard bench for alu_op_issue: random and directed stimulus
// against a table-driven reference model; monitor checks on negedge.
module tb_alu_op_issue;

  localparam int OPW = 4;
  localparam int CW  = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic in_valid = 1'b0;
  logic [1:0] ALUOp = '0;
  logic [2:0] Funct3 = '0;
  logic [6:0] Funct7 = '0;
  logic is_rtype = 1'b0;
  logic stall = 1'b0;
  logic flush = 1'b0;
  logic [OPW-1:0] Operation;
  logic out_valid;
  logic is_branch;
  logic illegal;
  logic illegal_sticky;
`ifdef ALU_OP_ISSUE_ILLEGAL_CNT_EN
  logic [CW-1:0] illegal_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] op;
    bit v;
    bit br;
    bit il;
    bit st;
    int cnt;
  } exp_t;

  exp_t q[$];
  exp_t m;

  logic [3:0] arith_tbl [8];

  alu_op_issue #(
    .OPCODE_LENGTH(OPW),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .ALUOp(ALUOp),
    .Funct3(Funct3),
    .Funct7(Funct7),
    .is_rtype(is_rtype),
    .stall(stall),
    .flush(flush),
    .Operation(Operation),
    .out_valid(out_valid),
    .is_branch(is_branch),
    .illegal(illegal),
`ifdef ALU_OP_ISSUE_ILLEGAL_CNT_EN
    .illegal_sticky(illegal_sticky),
    .illegal_cnt(illegal_cnt)
`else
    .illegal_sticky(illegal_sticky)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t zero_state();
    exp_t z;
    z.op = 4'h0; z.v = 0; z.br = 0;
    z.il = 0; z.st = 0; z.cnt = 0;
    return z;
  endfunction

  task automatic ref_dec(input int aop, input int f3,
                         input bit f7b5, input bit rt,
                         output logic [3:0] op,
                         output bit br, output bit il);
    op = 4'h2; br = 0; il = 0;
    if (aop == 1) begin
      br = 1;
      if (f3 == 0 || f3 == 1) op = 4'h8;
      else if (f3 == 4) op = 4'h9;
      else if (f3 == 5) op = 4'hA;
      else il = 1;
    end else if (aop == 2) begin
      op = arith_tbl[f3];
      if (f3 == 3) il = 1;
      if (f3 == 0 && rt && f7b5) op = 4'h6;
      if (f3 == 5 && f7b5) op = 4'h7;
    end else if (aop == 3) begin
      il = 1;
    end
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // One accepted clock edge; the expected post-edge state is queued.
  task automatic step(input bit iv, input int aop, input int f3,
                      input logic [6:0] f7, input bit rt,
                      input bit st, input bit fl);
    logic [3:0] op;
    bit br, il;
    in_valid = iv; ALUOp = 2'(aop); Funct3 = 3'(f3);
    Funct7 = f7; is_rtype = rt; stall = st; flush = fl;
    @(posedge clk);
    if (fl) begin
      m.op = 0; m.v = 0; m.br = 0; m.il = 0;
    end else if (!st) begin
      if (!iv) begin
        m.op = 0; m.v = 0; m.br = 0; m.il = 0;
      end else begin
        ref_dec(aop, f3, f7[5], rt, op, br, il);
        m.op = op; m.v = 1; m.br = br; m.il = il;
        if (il) begin
          m.st = 1;
          if (m.cnt < CNT_MAX) m.cnt++;
        end
      end
    end
    q.push_back(m);
    #1;
  endtask

  task automatic dchk(input string name, input logic [3:0] op,
                      input bit v, input bit br, input bit il);
    @(negedge clk);
    #1;
    chk({name, ".op"}, 32'(Operation), 32'(op));
    chk({name, ".valid"}, 32'(out_valid), 32'(v));
    chk({name, ".br"}, 32'(is_branch), 32'(br));
    chk({name, ".ill"}, 32'(illegal), 32'(il));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset_n && q.size() > 0) begin
      e = q.pop_front();
      chk("sb.op", 32'(Operation), 32'(e.op));
      chk("sb.valid", 32'(out_valid), 32'(e.v));
      chk("sb.br", 32'(is_branch), 32'(e.br));
      chk("sb.ill", 32'(illegal), 32'(e.il));
      chk("sb.sticky", 32'(illegal_sticky), 32'(e.st));
`ifdef ALU_OP_ISSUE_ILLEGAL_CNT_EN
      chk("sb.cnt", 32'(illegal_cnt), 32'(e.cnt));
`endif
    end
  end

  initial begin
    arith_tbl = '{4'h2, 4'h4, 4'hC, 4'h2,
                  4'h3, 4'h5, 4'h1, 4'h0};
    m = zero_state();
    #1 reset_n = 1'b0;
    #1;
    chk("rst.op", 32'(Operation), 0);
    chk("rst.valid", 32'(out_valid), 0);
    chk("rst.sticky", 32'(illegal_sticky), 0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;

    step(1, 3, 0, 7'h00, 0, 0, 1);
    dchk("flush_ill", 4'h0, 0, 0, 0);
    chk("flush_ill.sticky", 32'(illegal_sticky), 0);
    step(1, 3, 0, 7'h00, 0, 1, 0);
    dchk("stall_ill", 4'h0, 0, 0, 0);
    chk("stall_ill.sticky", 32'(illegal_sticky), 0);
`ifdef ALU_OP_ISSUE_ILLEGAL_CNT_EN
    chk("stall_ill.cnt", 32'(illegal_cnt), 0);
`endif

    step(1, 2, 0, 7'h20, 1, 0, 0);
    dchk("sub", 4'h6, 1, 0, 0);
    step(1, 2, 0, 7'h20, 0, 0, 0);
    dchk("addi", 4'h2, 1, 0, 0);
    step(1, 1, 5, 7'h00, 0, 0, 0);
    dchk("bge", 4'hA, 1, 1, 0);
    step(1, 1, 2, 7'h00, 0, 0, 0);
    dchk("br_ill", 4'h2, 1, 1, 1);
    chk("br_ill.sticky", 32'(illegal_sticky), 1);

    step(1, 2, 4, 7'h00, 1, 0, 0);
    dchk("xor", 4'h3, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 2, 7, 7'h00, 1, 1, 0);
      dchk("stall_hold", 4'h3, 1, 0, 0);
    end
    step(1, 2, 7, 7'h00, 1, 0, 0);
    dchk("and_release", 4'h0, 1, 0, 0);

    step(1, 2, 5, 7'h00, 1, 1, 1);
    dchk("flush_over_stall", 4'h0, 0, 0, 0);
    step(0, 2, 4, 7'h00, 1, 0, 0);
    dchk("invalid_bubble", 4'h0, 0, 0, 0);

    step(1, 2, 1, 7'h00, 1, 0, 0);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst.op", 32'(Operation), 0);
    chk("midrst.valid", 32'(out_valid), 0);
    chk("midrst.sticky", 32'(illegal_sticky), 0);
    m = zero_state();
    #1 reset_n = 1'b1;

    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0,
           int'($urandom_range(0, 3)),
           int'($urandom_range(0, 7)),
           7'($urandom), bit'($urandom_range(0, 1)),
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 7) == 0);
    end

    for (int i = 0; i < 300; i++)
      step(1, 3, 0, 7'h00, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("sat.sticky", 32'(illegal_sticky), 1);
`ifdef ALU_OP_ISSUE_ILLEGAL_CNT_EN
    chk("sat.cnt", 32'(illegal_cnt), 32'(CNT_MAX));
`endif
    chk("queue_drained", 32'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
